// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulate-and-resolve block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding and default widths (carry-save input, accumulator, resolve chunk).
package csa_pkg;

  localparam int IN_W_DEF    = 24;
  localparam int ACC_W_DEF   = 32;
  localparam int CHUNK_W_DEF = 8;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

endpackage

// File: rtl/csa_4to2.sv
// Combinational 4:2 carry-save compressor built from two cascaded 3:2 rows.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b, c, d - ACC_W operands; sum_o, carry_o - redundant result, carry already
//        shifted to its weight, with bits pushed past ACC_W dropped (modulo 2^ACC_W).
module csa_4to2 #(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic [ACC_W-1:0] c,
  input  logic [ACC_W-1:0] d,
  output logic [ACC_W-1:0] sum_o,
  output logic [ACC_W-1:0] carry_o
);

  logic [ACC_W-1:0] s1;
  logic [ACC_W-1:0] maj1;
  logic [ACC_W-1:0] c1;
  logic [ACC_W-1:0] maj2;

  // Row 1: a + b + c
  assign s1   = a ^ b ^ c;
  assign maj1 = (a & b) | (a & c) | (b & c);
  assign c1   = maj1 << 1;

  // Row 2: s1 + c1 + d
  assign sum_o   = s1 ^ c1 ^ d;
  assign maj2    = (s1 & c1) | (s1 & d) | (c1 & d);
  assign carry_o = maj2 << 1;

endmodule

// File: rtl/csa_accum_resolve.sv
// Accumulates carry-save beats in redundant form, then resolves the total CHUNK_W bits per cycle.
// Latency: result valid NCH cycles after the edge accepting the last beat of a group.
// Backpressure: in_ready only while accumulating; result held in OUT until out_ready.
// Ports: in_valid/in_ready/in_sum/in_carry/in_last - carry-save beat input;
//        out_valid/out_ready/out_data/out_cnt - resolved group sum and beat count (zero when idle).
module csa_accum_resolve
  import csa_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic [IN_W-1:0]  in_carry,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [7:0]       out_cnt
);

  localparam int NCH   = ACC_W / CHUNK_W;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t state, state_nxt;

  // Accumulators and result kept as chunk arrays so RESOLVE can index one slice per cycle.
  logic [NCH-1:0][CHUNK_W-1:0] acc_s;
  logic [NCH-1:0][CHUNK_W-1:0] acc_c;
  logic [NCH-1:0][CHUNK_W-1:0] res;
  logic [7:0]                  cnt;
  logic [IDX_W-1:0]            idx;
  logic                        cc;

  logic [ACC_W-1:0] nxt_s;
  logic [ACC_W-1:0] nxt_c;
  logic [CHUNK_W:0] csum;
  logic             accept;
  logic             idx_last;

  csa_4to2 #(.ACC_W(ACC_W)) u_csa (
    .a       (acc_s),
    .b       (acc_c),
    .c       (ACC_W'(in_sum)),
    .d       (ACC_W'(in_carry)),
    .sum_o   (nxt_s),
    .carry_o (nxt_c)
  );

  // The only carry-propagate adder: one chunk plus the carry from the previous chunk.
  assign csum     = {1'b0, acc_s[idx]} + {1'b0, acc_c[idx]} + {{CHUNK_W{1'b0}}, cc};
  assign idx_last = (idx == IDX_W'(NCH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && in_last) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (idx_last) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_s <= '0;
      acc_c <= '0;
      res   <= '0;
      cnt   <= '0;
      idx   <= '0;
      cc    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_s <= nxt_s;
            acc_c <= nxt_c;
            cnt   <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            if (in_last) begin
              idx <= '0;
              cc  <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          res[idx] <= csum[CHUNK_W-1:0];
          // Carry out of the top chunk lands here but is never consumed.
          cc       <= csum[CHUNK_W];
          idx      <= idx + IDX_W'(1);
        end
        OUT: begin
          if (out_ready) begin
            acc_s <= '0;
            acc_c <= '0;
            cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_valid ? res : '0;
  assign out_cnt  = out_valid ? cnt : 8'd0;

endmodule

// File: tb/tb_csa_accum_resolve.sv
module tb_csa_accum_resolve;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_sum;
  logic [23:0] in_carry;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csa_accum_resolve #(.IN_W(24), .ACC_W(32), .CHUNK_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  typedef struct {
    int              n;
    logic [3:0][23:0] s;
    logic [3:0][23:0] c;
    logic [31:0]     exp_d;
    logic [7:0]      exp_c;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it for exactly one accepting edge.
  task automatic send_beat(input logic [23:0] s, input logic [23:0] c, input logic last);
    check("in_ready_before_beat", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the edge that accepted the last beat: checks latency, result, handshake.
  task automatic collect(input string nm, input logic [31:0] exp_d, input logic [7:0] exp_c);
    for (int k = 1; k <= NCH; k++) begin
      tick();
      if (k < NCH) begin
        check({nm, "_ov_early"}, {31'd0, out_valid}, 32'd0);
        check({nm, "_data_idle"}, out_data, 32'd0);
      end else begin
        check({nm, "_ov"}, {31'd0, out_valid}, 32'd1);
      end
    end
    check({nm, "_data"}, out_data, exp_d);
    check({nm, "_cnt"}, {24'd0, out_cnt}, {24'd0, exp_c});
    check({nm, "_in_ready_out"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, "_ov_after"}, {31'd0, out_valid}, 32'd0);
    check({nm, "_data_after"}, out_data, 32'd0);
    check({nm, "_cnt_after"}, {24'd0, out_cnt}, 32'd0);
  endtask

  initial begin
    vt[0].n = 1; vt[0].s = {24'h0, 24'h0, 24'h0, 24'h000005};
    vt[0].c = {24'h0, 24'h0, 24'h0, 24'h000006};
    vt[0].exp_d = 32'h0000000B; vt[0].exp_c = 8'd1;
    vt[1].n = 3; vt[1].s = {24'h0, 24'h000000, 24'h800000, 24'hFFFFFF};
    vt[1].c = {24'h0, 24'h000002, 24'h800000, 24'h000001};
    vt[1].exp_d = 32'h02000002; vt[1].exp_c = 8'd3;
    vt[2].n = 2; vt[2].s = {24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF};
    vt[2].c = {24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF};
    vt[2].exp_d = 32'h03FFFFFC; vt[2].exp_c = 8'd2;
    vt[3].n = 4; vt[3].s = {24'h000001, 24'h00FF00, 24'h000000, 24'h123456};
    vt[3].c = {24'h000000, 24'h0000FF, 24'h000000, 24'h000001};
    vt[3].exp_d = 32'h00133457; vt[3].exp_c = 8'd4;
    vt[4].n = 1; vt[4].s = {24'h0, 24'h0, 24'h0, 24'h000000};
    vt[4].c = {24'h0, 24'h0, 24'h0, 24'h000000};
    vt[4].exp_d = 32'h00000000; vt[4].exp_c = 8'd1;
    vt[5].n = 1; vt[5].s = {24'h0, 24'h0, 24'h0, 24'h0000FF};
    vt[5].c = {24'h0, 24'h0, 24'h0, 24'h000001};
    vt[5].exp_d = 32'h00000100; vt[5].exp_c = 8'd1;

    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = '0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_cnt", {24'd0, out_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven groups
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vt[v].n; b++)
        send_beat(vt[v].s[b], vt[v].c[b], (b == vt[v].n - 1));
      collect($sformatf("vec%0d", v), vt[v].exp_d, vt[v].exp_c);
    end

    // 256 maximal beats: wraps the accumulator and saturates the count
    for (int b = 0; b < 256; b++)
      send_beat(24'hFFFFFF, 24'hFFFFFF, (b == 255));
    collect("sat256", 32'hFFFFFE00, 8'd255);

    // Stalled output with input pressure: nothing may be consumed, including on the handshake edge
    send_beat(24'h000001, 24'h000002, 1'b1);
    repeat (NCH) tick();
    in_valid = 1'b1; in_sum = 24'h000100; in_carry = 24'h0; in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_ov", {31'd0, out_valid}, 32'd1);
      check("stall_data", out_data, 32'h00000003);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    check("stall_cnt", {24'd0, out_cnt}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("stall_release_ov", {31'd0, out_valid}, 32'd0);
    send_beat(24'h000007, 24'h000000, 1'b1);
    collect("after_stall", 32'h00000007, 8'd1);

    // Reset sampled on the 2nd RESOLVE edge discards the group
    send_beat(24'h000010, 24'h000020, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_ov", {31'd0, out_valid}, 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_cnt", {24'd0, out_cnt}, 32'd0);
    for (int k = 0; k < NCH + 2; k++) begin
      tick();
      check("midrst_no_emit", {31'd0, out_valid}, 32'd0);
    end
    send_beat(24'h000001, 24'h000001, 1'b1);
    collect("after_rst", 32'h00000002, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/csa_accum_resolve.md
CSA_ACCUM_RESOLVE -- requirements
Module: csa_accum_resolve

Interface
REQ-001 Parameter IN_W, default 24: width of incoming carry-save sum and carry vectors.
REQ-002 Parameter ACC_W, default 32: width of the accumulator and result (ACC_W >= IN_W).
REQ-003 Parameter CHUNK_W, default 8: bits resolved per cycle; ACC_W SHALL be a multiple of CHUNK_W; NCH = ACC_W/CHUNK_W.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  a carry-save beat is presented.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_sum  input  IN_W  sum vector from the upstream 3:2 stage.
REQ-009 in_carry  input  IN_W  carry vector, already weight-aligned (bit 0 = weight 1).
REQ-010 in_last  input  1  beat is the final one of the accumulation group.
REQ-011 out_valid  output  1  resolved result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out_data  output  ACC_W  binary sum of all beats in the group, modulo 2^ACC_W.
REQ-014 out_cnt  output  8  number of beats in the group, saturating at 255.

Function
REQ-015 The FSM SHALL have states ACCUM, RESOLVE and OUT; reset state is ACCUM.
REQ-016 in_ready SHALL be 1 only in ACCUM; out_valid SHALL be 1 only in OUT.
REQ-017 A beat is accepted on a rising edge with in_valid & in_ready; beats presented outside ACCUM SHALL be ignored and not consumed.
REQ-018 On accept: {acc_s, acc_c} <= 4:2 compression of acc_s, acc_c, zero-extended in_sum and in_carry, modulo 2^ACC_W, with shifted-out carries discarded.
REQ-019 On accept: beat count increments, saturating at 255.
REQ-020 Accept with in_last=1 SHALL move ACCUM->RESOLVE and clear the chunk index and chunk carry.
REQ-021 RESOLVE SHALL add one CHUNK_W slice of acc_s + acc_c + chunk carry per cycle, LSB chunk first, into the result register, lasting exactly NCH cycles.
REQ-022 out_valid SHALL rise at the NCH-th rising edge after the edge that accepted in_last; the carry out of the top chunk is discarded.
REQ-023 In OUT, out_data and out_cnt SHALL hold stable until out_valid & out_ready.
REQ-024 On the OUT handshake edge: go to ACCUM; clear acc_s, acc_c and the count. No beat is accepted on that edge, because in_ready=0.
REQ-025 out_data and out_cnt SHALL read 0 whenever out_valid=0.
REQ-026 The accumulator SHALL wrap silently; no overflow indication.

Reset
REQ-027 With rst_n=0 at a rising edge, in every state including mid-RESOLVE: state=ACCUM; accumulators, result, count and chunk index cleared; in_ready=1 after the edge, out_valid=0, out_data=0, out_cnt=0.
REQ-028 A group in progress at reset SHALL be discarded and never emitted.

Structure
REQ-029 Shared package csa_pkg SHALL hold the FSM state enum and the default IN_W/ACC_W/CHUNK_W constants.
REQ-030 The 4:2 compression SHALL be a combinational sub-module csa_4to2, built as two cascaded 3:2 rows, parameterised by ACC_W.
REQ-031 RTL SHALL contain no full-width carry-propagate adder; only the CHUNK_W adder in RESOLVE.

Verification (ACC_W=32, CHUNK_W=8, NCH=4)
REQ-032 Single beat sum=0x000005, carry=0x000006, last=1 -> out_valid at 4th edge after accept; out_data=0x0000000B, out_cnt=1.
REQ-033 Beats (0xFFFFFF,0x000001), (0x800000,0x800000), (0x000000,0x000002, last) -> out_data=0x02000002, out_cnt=3.
REQ-034 256 beats of (0xFFFFFF,0xFFFFFF), last on the 256th -> out_data=0xFFFFFE00, out_cnt=255.
REQ-035 out_ready held 0 for 5 cycles in OUT while in_valid=1 -> out_data stable, in_ready=0, no beat consumed; the first beat after the handshake starts a new group from zero.
REQ-036 rst_n=0 at 2nd RESOLVE cycle -> next cycle state ACCUM, out_valid=0, out_data=0; a following single beat (1,1,last) yields out_data=2, out_cnt=1.
